excp_ctrl: RTL
==============

# excp_ctrl

Exception/interrupt commit controller between the writeback stage and the CP0 register file of the 5-stage MIPS pipeline. It samples the instruction leaving WB, arbitrates between pending interrupts, instruction-carried exceptions and ERET, and blocks architectural commit of a trapping instruction. It emits one-cycle CP0 update pulses, holds a pipeline-wide flush, and sequences the fetch redirect to the exception vector or EPC through a valid/ready handshake.

## Interface
- EXC_VECTOR, 32'hbfc0_0380, exception entry PC
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- ws_valid  in  1  WB holds a valid instruction this cycle
- ws_pc  in  32  PC of WB instruction
- ws_bd  in  1  WB instruction is in a delay slot
- ws_ex  in  1  WB instruction carries an exception
- ws_excode  in  5  ExcCode carried with ws_ex
- ws_badvaddr  in  32  faulting address (AdEL/AdES)
- ws_eret  in  1  WB instruction is ERET
- cp0_ie / cp0_exl  in  1 / 1  Status.IE, Status.EXL
- cp0_im / cp0_ip  in  8 / 8  Status.IM, Cause.IP
- cp0_epc  in  32  current EPC
- ws_commit_ok  out  1  WB may write regfile/CP0 this cycle
- cp0_excp_valid  out  1  one-cycle exception-entry pulse to CP0
- cp0_excode  out  5  ExcCode for Cause
- cp0_pc / cp0_bd / cp0_badvaddr  out  32 / 1 / 32  trap PC, BD flag, BadVAddr
- cp0_eret  out  1  one-cycle ERET pulse to CP0 (clears EXL)
- flush  out  1  squash all stages IF..MEM and WB input latch
- redirect_valid  out  1  redirect PC offered to fetch
- redirect_pc  out  32  redirect target
- redirect_ready  in  1  fetch accepts redirect

## Operation
- int_pending = cp0_ie & ~cp0_exl & |(cp0_ip & cp0_im).
- Trigger in IDLE when ws_valid and any of: int_pending, ws_ex, ws_eret. Priority: interrupt > ws_ex > eret.
- Interrupt: excode 5'h00, trap PC = ws_pc, ws_bd passed through; the WB instruction is not committed.
- Exception: excode = ws_excode; badvaddr forwarded unchanged (CP0 decides whether to latch it).
- ERET (no int, no ws_ex): no exception pulse; target = cp0_epc sampled at trigger.
- ws_commit_ok = ws_valid & (state==IDLE) & ~trigger_any_except_eret; ERET itself commits nothing.
- FSM states IDLE, COMMIT, REDIRECT.
  - IDLE -> COMMIT on trigger; latch kind, excode, pc, bd, badvaddr, target (EXC_VECTOR or cp0_epc).
  - COMMIT (1 cycle): cp0_excp_valid or cp0_eret = 1; flush = 1; -> REDIRECT.
  - REDIRECT: flush = 1, redirect_valid = 1, redirect_pc stable; on redirect_ready -> IDLE.
- WB inputs ignored outside IDLE.
- Saturating 16-bit internal counter of cycles in REDIRECT; cleared on IDLE entry (debug, unexported except through hierarchy).

## Timing
- Reset: state IDLE; all outputs 0 except redirect_pc = EXC_VECTOR; latched fields 0.
- Trigger at cycle T -> CP0 pulse and flush at T+1 -> redirect_valid from T+2.
- redirect_ready high in the first REDIRECT cycle -> IDLE at T+3; minimum trap turnaround 3 cycles.
- redirect_ready while not in REDIRECT is ignored.
- flush deasserts the cycle state returns to IDLE.
- Reset in any state -> IDLE next cycle, no pulse emitted, redirect dropped.
- int_pending and ws_eret together: interrupt wins, ERET not executed, EPC = ERET PC.
- cp0_exl = 1 masks interrupts; ws_ex still traps (CP0 keeps EPC while EXL set).

## Structure
- Shared constants in mycpu.h: EXC_INT 5'h00, EXC_ADEL 5'h04, EXC_ADES 5'h05, EXC_SYS 5'h08, EXC_BP 5'h09, EXC_RI 5'h0a, EXC_OV 5'h0c, EXC_VECTOR, state encodings.
- One sub-module: excp_prio, combinational priority select (int/ex/eret) producing kind, excode, target.

## Test plan
- ws_valid, ws_ex, excode 5'h08, pc 32'hbfc0_1000 -> T+1 cp0_excp_valid=1, excode 08, cp0_pc bfc0_1000; T+2 redirect_pc bfc0_0380; ws_commit_ok=0 at T.
- ie=1, exl=0, im=8'h80, ip=8'h80, ws_valid pc 32'h1234 bd=1 -> excode 00, cp0_bd=1, cp0_pc 1234, instruction not committed.
- ws_eret, cp0_epc 32'hbfc0_2000 -> T+1 cp0_eret=1, no excp pulse; redirect_pc bfc0_2000.
- Interrupt + ws_eret same cycle -> excode 00, cp0_eret stays 0, redirect bfc0_0380.
- redirect_ready held low 5 cycles -> redirect_valid/flush held, redirect_pc stable; ready -> IDLE next cycle.
- Reset asserted during REDIRECT -> next cycle all outputs 0, redirect_pc bfc0_0380, new trigger accepted normally.

Source files
------------

// File: rtl/excp_ctrl_pkg.sv
// Shared constants and types for the WB exception/interrupt commit controller.
// ExcCodes follow the MIPS32 Cause.ExcCode encoding.
package excp_ctrl_pkg;

    localparam logic [4:0]  EXC_INT    = 5'h00;
    localparam logic [4:0]  EXC_ADEL   = 5'h04;
    localparam logic [4:0]  EXC_ADES   = 5'h05;
    localparam logic [4:0]  EXC_SYS    = 5'h08;
    localparam logic [4:0]  EXC_BP     = 5'h09;
    localparam logic [4:0]  EXC_RI     = 5'h0a;
    localparam logic [4:0]  EXC_OV     = 5'h0c;
    localparam logic [31:0] EXC_VECTOR = 32'hbfc0_0380;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COMMIT,
        ST_REDIRECT
    } state_t;

    typedef enum logic [1:0] {
        KIND_NONE,
        KIND_INT,
        KIND_EXC,
        KIND_ERET
    } kind_t;

    function automatic logic int_pending_f(input logic ie, input logic exl,
                                           input logic [7:0] ip, input logic [7:0] im);
        return ie & ~exl & (|(ip & im));
    endfunction

endpackage

// File: rtl/excp_ctrl_if.sv
// WB-stage, CP0 and fetch-redirect signals seen by the exception controller.
// slave is the controller side; master is the pipeline/CP0/fetch side.
interface excp_ctrl_if;

    logic        ws_valid;
    logic [31:0] ws_pc;
    logic        ws_bd;
    logic        ws_ex;
    logic [4:0]  ws_excode;
    logic [31:0] ws_badvaddr;
    logic        ws_eret;
    logic        cp0_ie;
    logic        cp0_exl;
    logic [7:0]  cp0_im;
    logic [7:0]  cp0_ip;
    logic [31:0] cp0_epc;
    logic        ws_commit_ok;
    logic        cp0_excp_valid;
    logic [4:0]  cp0_excode;
    logic [31:0] cp0_pc;
    logic        cp0_bd;
    logic [31:0] cp0_badvaddr;
    logic        cp0_eret;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        redirect_ready;

    modport slave (
        input  ws_valid, ws_pc, ws_bd, ws_ex, ws_excode, ws_badvaddr, ws_eret,
        input  cp0_ie, cp0_exl, cp0_im, cp0_ip, cp0_epc, redirect_ready,
        output ws_commit_ok, cp0_excp_valid, cp0_excode, cp0_pc, cp0_bd,
        output cp0_badvaddr, cp0_eret, flush, redirect_valid, redirect_pc
    );

    modport master (
        output ws_valid, ws_pc, ws_bd, ws_ex, ws_excode, ws_badvaddr, ws_eret,
        output cp0_ie, cp0_exl, cp0_im, cp0_ip, cp0_epc, redirect_ready,
        input  ws_commit_ok, cp0_excp_valid, cp0_excode, cp0_pc, cp0_bd,
        input  cp0_badvaddr, cp0_eret, flush, redirect_valid, redirect_pc
    );

endinterface

// File: rtl/excp_ctrl_prio.sv
// Combinational priority select between interrupt, carried exception and ERET.
// Produces the trap kind, its ExcCode and the redirect target.
module excp_prio
    import excp_ctrl_pkg::*;
(
    input  logic        int_pending,
    input  logic        ws_ex,
    input  logic [4:0]  ws_excode,
    input  logic        ws_eret,
    input  logic [31:0] cp0_epc,
    output kind_t       kind,
    output logic [4:0]  excode,
    output logic [31:0] target
);

    always_comb begin
        kind   = KIND_NONE;
        excode = EXC_INT;
        target = EXC_VECTOR;
        if (int_pending) begin
            kind = KIND_INT;
        end else if (ws_ex) begin
            kind   = KIND_EXC;
            excode = ws_excode;
        end else if (ws_eret) begin
            kind   = KIND_ERET;
            target = cp0_epc;
        end
    end

endmodule

// File: rtl/excp_ctrl.sv
// Exception/interrupt commit controller: samples WB, pulses CP0, holds flush,
// and offers the fetch redirect until accepted.
module excp_ctrl
    import excp_ctrl_pkg::*;
(
    input  logic clk,
    input  logic reset,
    excp_ctrl_if.slave bus
);

    state_t      state;
    state_t      state_nxt;
    kind_t       prio_kind;
    logic [4:0]  prio_excode;
    logic [31:0] prio_target;
    logic        int_pend;
    logic        trigger;

    kind_t       kind_q;
    logic [4:0]  excode_q;
    logic [31:0] pc_q;
    logic        bd_q;
    logic [31:0] badvaddr_q;
    logic [31:0] target_q;
    logic [15:0] redir_cycles;

    logic        excp_pulse;
    logic        eret_pulse;
    logic        flush_c;
    logic        redir_valid_c;

    assign int_pend = int_pending_f(bus.cp0_ie, bus.cp0_exl, bus.cp0_ip, bus.cp0_im);

    excp_prio u_prio (
        .int_pending (int_pend),
        .ws_ex       (bus.ws_ex),
        .ws_excode   (bus.ws_excode),
        .ws_eret     (bus.ws_eret),
        .cp0_epc     (bus.cp0_epc),
        .kind        (prio_kind),
        .excode      (prio_excode),
        .target      (prio_target)
    );

    assign trigger = bus.ws_valid & (prio_kind != KIND_NONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // The trap context is captured only on an IDLE trigger; WB is ignored otherwise.
    always_ff @(posedge clk) begin
        if (reset) begin
            kind_q     <= KIND_NONE;
            excode_q   <= '0;
            pc_q       <= '0;
            bd_q       <= 1'b0;
            badvaddr_q <= '0;
            target_q   <= EXC_VECTOR;
        end else if (state == ST_IDLE && trigger) begin
            kind_q     <= prio_kind;
            excode_q   <= prio_excode;
            pc_q       <= bus.ws_pc;
            bd_q       <= bus.ws_bd;
            badvaddr_q <= bus.ws_badvaddr;
            target_q   <= prio_target;
        end
    end

    // Debug only: saturating count of cycles spent waiting for fetch to accept.
    always_ff @(posedge clk) begin
        if (reset || state_nxt == ST_IDLE) begin
            redir_cycles <= '0;
        end else if (state == ST_REDIRECT && redir_cycles != '1) begin
            redir_cycles <= redir_cycles + 16'd1;
        end
    end

    always_comb begin
        state_nxt     = state;
        excp_pulse    = 1'b0;
        eret_pulse    = 1'b0;
        flush_c       = 1'b0;
        redir_valid_c = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (trigger) state_nxt = ST_COMMIT;
            end
            ST_COMMIT: begin
                excp_pulse = (kind_q == KIND_INT) || (kind_q == KIND_EXC);
                eret_pulse = (kind_q == KIND_ERET);
                flush_c    = 1'b1;
                state_nxt  = ST_REDIRECT;
            end
            ST_REDIRECT: begin
                flush_c       = 1'b1;
                redir_valid_c = 1'b1;
                if (bus.redirect_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign bus.ws_commit_ok   = bus.ws_valid & (state == ST_IDLE) & ~(int_pend | bus.ws_ex);
    assign bus.cp0_excp_valid = excp_pulse;
    assign bus.cp0_eret       = eret_pulse;
    assign bus.cp0_excode     = excode_q;
    assign bus.cp0_pc         = pc_q;
    assign bus.cp0_bd         = bd_q;
    assign bus.cp0_badvaddr   = badvaddr_q;
    assign bus.flush          = flush_c;
    assign bus.redirect_valid = redir_valid_c;
    assign bus.redirect_pc    = target_q;

endmodule
